// File: rtl/ft245_device_emu_if.sv
// Pin and PC-stream bundle for the FT245 device emulator.
// Handshake semantics: a stream transfer happens in exactly the cycle where
// the producer's valid (pc_tx_rdy / pc_rx_rdy) and the consumer's acceptance
// (pc_tx_ack / pc_rx_ack) are both high at the rising clock edge. A valid
// producer holds its data stable until that edge. The FT245 pins themselves
// are asynchronous-style strobes and flags, sampled through synchronizers.
interface ft245_device_emu_if #(
    parameter int WIDTH = 8
);
    logic             rxf_245;
    logic             rx_245;
    logic             txe_245;
    logic             wr_245;
    logic [WIDTH-1:0] dout_245;
    logic             oe_245;
    logic [WIDTH-1:0] din_245;
    logic [WIDTH-1:0] pc_tx_data;
    logic             pc_tx_rdy;
    logic             pc_tx_ack;
    logic [WIDTH-1:0] pc_rx_data;
    logic             pc_rx_rdy;
    logic             pc_rx_ack;
    logic             err_rd;
    logic             err_wr;

    // Device (chip) side.
    modport slave (
        output rxf_245, txe_245, dout_245, oe_245,
        output pc_tx_ack, pc_rx_data, pc_rx_rdy, err_rd, err_wr,
        input  rx_245, wr_245, din_245, pc_tx_data, pc_tx_rdy, pc_rx_ack
    );

    // Host bus plus PC-side stream driver.
    modport master (
        input  rxf_245, txe_245, dout_245, oe_245,
        input  pc_tx_ack, pc_rx_data, pc_rx_rdy, err_rd, err_wr,
        output rx_245, wr_245, din_245, pc_tx_data, pc_tx_rdy, pc_rx_ack
    );
endinterface

// File: rtl/ft245_device_emu.sv
// FT245 chip-side emulator: RX FIFO (PC -> host) served by a read FSM,
// TX FIFO (host -> PC) filled by a write FSM. Bus timing in clock cycles.
module ft245_device_emu #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int RD_LAT     = 2,
    parameter int RXF_PRE    = 2,
    parameter int TXE_PRE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ft245_device_emu_if.slave    bus,
    output logic [1:0]           rd_state_dbg,
    output logic [1:0]           wr_state_dbg
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int CW    = 8;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_PRE} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_STROBE, W_PRE} w_state_t;

    // Synchronizers plus one delay stage for edge detection.
    logic             rx_s1, rx_s2, rx_d;
    logic             wr_s1, wr_s2, wr_d;
    logic [WIDTH-1:0] din_s1, din_s2;
    logic             alive;   // low only until the first edge after reset

    // Two-flop synchronizers; strobes reset to their idle levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
            wr_s1 <= 1'b0; wr_s2 <= 1'b0; wr_d <= 1'b0;
            din_s1 <= '0;  din_s2 <= '0;
            alive  <= 1'b0;
        end else begin
            rx_s1 <= bus.rx_245;  rx_s2 <= rx_s1;  rx_d <= rx_s2;
            wr_s1 <= bus.wr_245;  wr_s2 <= wr_s1;  wr_d <= wr_s2;
            din_s1 <= bus.din_245; din_s2 <= din_s1;
            alive  <= 1'b1;
        end
    end

    logic rx_fall, rx_rise, wr_rise, wr_fall;
    assign rx_fall = rx_d & ~rx_s2;
    assign rx_rise = ~rx_d & rx_s2;
    assign wr_rise = ~wr_d & wr_s2;
    assign wr_fall = wr_d & ~wr_s2;

    // ---------------- FIFOs ----------------
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [PW-1:0]    rx_wp, rx_rp, tx_wp, tx_rp;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             rx_push, rx_pop, tx_push, tx_pop;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[PW-1] != rx_rp[PW-1]) &&
                      (rx_wp[PW-2:0] == rx_rp[PW-2:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[PW-1] != tx_rp[PW-1]) &&
                      (tx_wp[PW-2:0] == tx_rp[PW-2:0]);

    assign rx_push       = alive & bus.pc_tx_rdy & ~rx_full;
    assign bus.pc_tx_ack = rx_push;
    assign tx_pop        = bus.pc_rx_ack & ~tx_empty;
    assign bus.pc_rx_rdy = ~tx_empty;
    assign bus.pc_rx_data = tx_mem[tx_rp[PW-2:0]];

    // FIFO storage writes; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[PW-2:0]] <= bus.pc_tx_data;
        if (tx_push) tx_mem[tx_wp[PW-2:0]] <= din_s2;
    end

    // FIFO pointers, wrapping naturally at 2^PW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp <= '0; rx_rp <= '0; tx_wp <= '0; tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
        end
    end

    // ---------------- Read FSM ----------------
    r_state_t        r_state, r_next;
    logic [CW-1:0]   r_cnt, r_cnt_next;
    logic            err_rd_set, rxf;

    // Read FSM state, counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            bus.err_rd <= 1'b0;
        end else begin
            r_state <= r_next;
            r_cnt   <= r_cnt_next;
            if (err_rd_set) bus.err_rd <= 1'b1;
        end
    end

    // Read FSM next state; a pop happens only on a completed strobe.
    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        rx_pop     = 1'b0;
        err_rd_set = 1'b0;
        unique case (r_state)
            R_IDLE: if (rx_fall) begin
                if (rxf) err_rd_set = 1'b1;
                else begin r_next = R_WAIT; r_cnt_next = '0; end
            end
            R_WAIT: begin
                if (rx_rise) begin r_next = R_PRE; r_cnt_next = '0; end
                else if (r_cnt == CW'(RD_LAT - 1)) r_next = R_DRIVE;
                else r_cnt_next = r_cnt + CW'(1);
            end
            R_DRIVE: if (rx_rise) begin
                rx_pop = 1'b1; r_next = R_PRE; r_cnt_next = '0;
            end
            R_PRE: begin
                if (rx_fall) err_rd_set = 1'b1;
                if (r_cnt == CW'(RXF_PRE - 1)) r_next = R_IDLE;
                else r_cnt_next = r_cnt + CW'(1);
            end
            default: r_next = R_IDLE;
        endcase
    end

    // rxf is frozen low for the whole strobe, independent of FIFO activity.
    assign rxf          = (r_state == R_IDLE) ? (rx_empty | ~alive) : (r_state == R_PRE);
    assign bus.rxf_245  = rxf;
    assign bus.oe_245   = (r_state == R_DRIVE);
    assign bus.dout_245 = (r_state == R_DRIVE) ? rx_mem[rx_rp[PW-2:0]] : '0;
    assign rd_state_dbg = r_state;

    // ---------------- Write FSM ----------------
    w_state_t        w_state, w_next;
    logic [CW-1:0]   w_cnt, w_cnt_next;
    logic            err_wr_set, txe;

    // Write FSM state, counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            w_cnt      <= '0;
            bus.err_wr <= 1'b0;
        end else begin
            w_state <= w_next;
            w_cnt   <= w_cnt_next;
            if (err_wr_set) bus.err_wr <= 1'b1;
        end
    end

    // Write FSM next state; the byte is pushed at the strobe's falling edge.
    always_comb begin
        w_next     = w_state;
        w_cnt_next = w_cnt;
        tx_push    = 1'b0;
        err_wr_set = 1'b0;
        unique case (w_state)
            W_IDLE: if (wr_rise) begin
                if (txe) err_wr_set = 1'b1;
                else w_next = W_STROBE;
            end
            W_STROBE: if (wr_fall) begin
                tx_push = ~tx_full; w_next = W_PRE; w_cnt_next = '0;
            end
            W_PRE: begin
                if (wr_rise) err_wr_set = 1'b1;
                if (w_cnt == CW'(TXE_PRE - 1)) w_next = W_IDLE;
                else w_cnt_next = w_cnt + CW'(1);
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign txe          = (w_state == W_IDLE) ? (tx_full | ~alive) : (w_state == W_PRE);
    assign bus.txe_245  = txe;
    assign wr_state_dbg = w_state;
endmodule

// File: tb/tb_ft245_device_emu.sv
// Bench for ft245_device_emu: host-bus and PC-stream driver tasks with
// expected-data queues for both directions.
module tb_ft245_device_emu;
    localparam int W       = 8;
    localparam int RXF_PRE = 2;
    localparam int TXE_PRE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ft245_device_emu_if #(.WIDTH(W)) bus ();
    logic [1:0] rd_state_dbg, wr_state_dbg;

    ft245_device_emu #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rd_state_dbg (rd_state_dbg),
        .wr_state_dbg (wr_state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] rd_exp_q[$];   // bytes the host should read
    logic [W-1:0] wr_exp_q[$];   // bytes the PC should receive
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pc_push(input logic [W-1:0] data, output bit acked);
        bus.pc_tx_data = data;
        bus.pc_tx_rdy  = 1'b1;
        #1;
        acked = bus.pc_tx_ack;
        @(posedge clk);
        #1;
        bus.pc_tx_rdy = 1'b0;
        if (acked) rd_exp_q.push_back(data);
    endtask

    task automatic pc_pop();
        logic [W-1:0] e;
        check("pc_rx_rdy", 32'(bus.pc_rx_rdy), 32'd1);
        if (wr_exp_q.size() == 0) check("wr_q_underflow", 32'd1, 32'd0);
        else begin
            e = wr_exp_q.pop_front();
            check("pc_rx_data", 32'(bus.pc_rx_data), 32'(e));
        end
        bus.pc_rx_ack = 1'b1;
        tick(1);
        bus.pc_rx_ack = 1'b0;
    endtask

    task automatic host_read();
        logic [W-1:0] e;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.rxf_245) begin ok = 1'b1; break; end
            tick(1);
        end
        check("rd_rxf_low", 32'(ok), 32'd1);
        if (!ok) return;
        bus.rx_245 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.oe_245) begin ok = 1'b1; break; end
        end
        check("rd_oe_high", 32'(ok), 32'd1);
        if (ok) begin
            if (rd_exp_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
            else begin
                e = rd_exp_q.pop_front();
                check("rd_data", 32'(bus.dout_245), 32'(e));
            end
        end
        bus.rx_245 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!bus.oe_245) begin ok = 1'b1; break; end
        end
        check("rd_oe_drop", 32'(ok), 32'd1);
        for (int i = 0; i < RXF_PRE; i++) begin
            check("rd_rxf_pre", 32'(bus.rxf_245), 32'd1);
            tick(1);
        end
    endtask

    task automatic host_write(input logic [W-1:0] data, input bit accept);
        bit ok;
        if (accept) check("wr_txe_low", 32'(bus.txe_245), 32'd0);
        bus.din_245 = data;
        bus.wr_245  = 1'b1;
        tick(4);
        bus.wr_245  = 1'b0;
        if (accept) wr_exp_q.push_back(data);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.txe_245) begin ok = 1'b1; break; end
        end
        check("wr_txe_high", 32'(ok), 32'd1);
        for (int i = 0; i < TXE_PRE; i++) begin
            check("wr_txe_pre", 32'(bus.txe_245), 32'd1);
            tick(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acked;
        logic [W-1:0] b0, b1;
        bus.rx_245 = 1'b1; bus.wr_245 = 1'b0; bus.din_245 = '0;
        bus.pc_tx_data = '0; bus.pc_tx_rdy = 1'b0; bus.pc_rx_ack = 1'b0;

        // Reset with strobes toggling and a PC byte offered.
        bus.pc_tx_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.rx_245 = ~bus.rx_245;
            bus.wr_245 = ~bus.wr_245;
            tick(1);
        end
        check("rst_rxf", 32'(bus.rxf_245), 32'd1);
        check("rst_txe", 32'(bus.txe_245), 32'd1);
        check("rst_oe", 32'(bus.oe_245), 32'd0);
        check("rst_dout", 32'(bus.dout_245), 32'd0);
        check("rst_ack", 32'(bus.pc_tx_ack), 32'd0);
        check("rst_err_rd", 32'(bus.err_rd), 32'd0);
        check("rst_err_wr", 32'(bus.err_wr), 32'd0);
        bus.pc_tx_rdy = 1'b0; bus.rx_245 = 1'b1; bus.wr_245 = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check("post_rst_txe", 32'(bus.txe_245), 32'd0);
        check("post_rst_rxf", 32'(bus.rxf_245), 32'd1);
        check("post_rst_rdy", 32'(bus.pc_rx_rdy), 32'd0);

        // PC-to-host read of 0xA5.
        pc_push(8'hA5, acked);
        check("tx_ack", 32'(acked), 32'd1);
        host_read();
        check("rd_empty_rxf", 32'(bus.rxf_245), 32'd1);

        // Host-to-PC write of 0x3C.
        host_write(8'h3C, 1'b1);
        pc_pop();
        check("pc_rx_rdy_empty", 32'(bus.pc_rx_rdy), 32'd0);

        // TX FIFO fill, drain, refill across pointer wrap.
        for (int i = 0; i < 16; i++) host_write(8'(i), 1'b1);
        tick(3);
        check("tx_full_txe", 32'(bus.txe_245), 32'd1);
        for (int i = 0; i < 16; i++) pc_pop();
        for (int i = 16; i < 32; i++) host_write(8'(i), 1'b1);
        for (int i = 0; i < 16; i++) pc_pop();
        check("tx_drained", 32'(bus.pc_rx_rdy), 32'd0);

        // RX FIFO fill with random bytes; 17th must be refused.
        for (int i = 0; i < 16; i++) begin
            pc_push(8'($urandom_range(0, 255)), acked);
            check("rx_fill_ack", 32'(acked), 32'd1);
        end
        pc_push(8'hFF, acked);
        check("rx_full_noack", 32'(acked), 32'd0);
        for (int i = 0; i < 16; i++) host_read();
        check("rx_drained_rxf", 32'(bus.rxf_245), 32'd1);

        // Read strobe with an empty RX FIFO.
        bus.rx_245 = 1'b0;
        tick(6);
        check("err_rd_set", 32'(bus.err_rd), 32'd1);
        check("err_rd_no_oe", 32'(bus.oe_245), 32'd0);
        bus.rx_245 = 1'b1;
        tick(6);
        check("err_rd_sticky", 32'(bus.err_rd), 32'd1);
        check("err_rd_rxf", 32'(bus.rxf_245), 32'd1);

        // Write strobe with a full TX FIFO.
        for (int i = 0; i < 16; i++) host_write(8'($urandom_range(0, 255)), 1'b1);
        check("err_wr_clear", 32'(bus.err_wr), 32'd0);
        host_write(8'hEE, 1'b0);
        check("err_wr_set", 32'(bus.err_wr), 32'd1);
        for (int i = 0; i < 16; i++) pc_pop();
        check("err_wr_unchanged", 32'(bus.pc_rx_rdy), 32'd0);

        // Overlapping read and write.
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        pc_push(b0, acked);
        check("conc_ack", 32'(acked), 32'd1);
        fork
            host_read();
            host_write(b1, 1'b1);
        join
        pc_pop();

        // Reset inside R_DRIVE with a byte also waiting in the TX FIFO.
        host_write(8'h77, 1'b1);
        pc_push(8'h99, acked);
        check("drv_ack", 32'(acked), 32'd1);
        bus.rx_245 = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.oe_245) begin acked = 1'b1; break; end
        end
        check("drv_oe", 32'(acked), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_drv_oe", 32'(bus.oe_245), 32'd0);
        check("rst_drv_rxf", 32'(bus.rxf_245), 32'd1);
        rd_exp_q.delete();
        wr_exp_q.delete();
        bus.rx_245 = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        check("rel_rxf", 32'(bus.rxf_245), 32'd1);
        check("rel_rdy", 32'(bus.pc_rx_rdy), 32'd0);
        check("rel_txe", 32'(bus.txe_245), 32'd0);
        check("rel_err_rd", 32'(bus.err_rd), 32'd0);
        check("rel_err_wr", 32'(bus.err_wr), 32'd0);

        // Traffic still flows after the aborted transfer.
        pc_push(8'h5A, acked);
        check("final_ack", 32'(acked), 32'd1);
        host_read();
        host_write(8'hC3, 1'b1);
        pc_pop();
        check("rd_q_left", 32'(rd_exp_q.size()), 32'd0);
        check("wr_q_left", 32'(wr_exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so a stuck DUT cannot hang the run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ft245_device_emu.md
Name: ft245_device_emu

Overview:
- Synthesizable emulator of the FT245 chip side of the FT245 asynchronous FIFO bus, driving the pins our FPGA-side FT245 interface consumes.
- Used for on-chip loopback and cocotb regression, so the host interface can be exercised without a USB chip.
- A "PC side" valid/ack stream pair feeds an internal RX FIFO and drains an internal TX FIFO.
- Bus timing is emulated in clock cycles.

Parameters:
- WIDTH, 8, data width of the bus and of the PC-side streams.
- DEPTH_LOG2, 4, log2 of each FIFO depth, so each FIFO holds 16 entries.
- RD_LAT, 2, cycles from a synchronized rx_245 fall to the cycle data is driven.
- RXF_PRE, 2, cycles rxf_245 is held high after a read strobe ends.
- TXE_PRE, 2, cycles txe_245 is held high after a write is captured.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- rxf_245  out  1  active-low flag: data is available to the host.
- rx_245  in  1  active-low read strobe (RD#) from the host.
- txe_245  out  1  active-low flag: the device can accept a write.
- wr_245  in  1  active-high write strobe from the host; data is captured on its falling edge.
- dout_245  out  WIDTH  data driven to the host bus.
- oe_245  out  1  bus drive enable for dout_245; the tristate pad sits outside this block.
- din_245  in  WIDTH  data from the host bus.
- pc_tx_data  in  WIDTH  PC-to-host byte.
- pc_tx_rdy  in  1  pc_tx_data is valid.
- pc_tx_ack  out  1  one-cycle pulse: byte pushed into the RX FIFO.
- pc_rx_data  out  WIDTH  head of the TX FIFO.
- pc_rx_rdy  out  1  TX FIFO not empty.
- pc_rx_ack  in  1  pop the TX FIFO.
- err_rd  out  1  sticky: read strobe seen while rxf_245 was high.
- err_wr  out  1  sticky: write strobe seen while txe_245 was high.

Behaviour:
- Reset (rst=0, asynchronous):
  - rxf_245=1, txe_245=1, oe_245=0, dout_245=0, pc_tx_ack=0, err_rd=0, err_wr=0.
  - Both FIFOs emptied; both FSMs go to IDLE.
  - Reset asserted mid-transfer aborts it; no partial byte is pushed or popped.
- Input synchronization:
  - rx_245, wr_245 and din_245 each pass through 2-flop synchronizers.
  - All edge detection uses the synchronized values.
  - din_245 is captured from its second sync stage at the detected wr_245 fall.
- RX FIFO (PC to host):
  - pc_tx_ack=1 in the cycle pc_tx_rdy=1 and the FIFO is not full; the byte is written that edge.
  - When full, pc_tx_ack=0.
  - Read FSM pop and PC push in the same cycle are both honoured.
- TX FIFO (host to PC):
  - pc_rx_data is the head entry; it is valid when pc_rx_rdy=1.
  - pc_rx_ack while pc_rx_rdy=1 pops the head. Ack while empty is ignored.
- Read FSM:
  - R_IDLE: rxf_245 = (RX FIFO empty). A sync rx_245 fall with rxf_245=0 goes to R_WAIT; with rxf_245=1 it sets err_rd and the FSM stays in R_IDLE.
  - R_WAIT: counts RD_LAT cycles, then goes to R_DRIVE. If rx_245 rises early, go to R_PRE with no pop.
  - R_DRIVE: oe_245=1, dout_245=RX FIFO head. On a sync rx_245 rise: pop the head, set oe_245=0 and rxf_245=1, go to R_PRE.
  - R_PRE: rxf_245=1 for RXF_PRE cycles, then R_IDLE.
  - rxf_245 stays low from R_WAIT through R_DRIVE even if the FIFO changes.
- Write FSM:
  - W_IDLE: txe_245 = (TX FIFO full). A sync wr_245 rise goes to W_STROBE; if txe_245 was 1, set err_wr and the FSM stays in W_IDLE.
  - W_STROBE: on a sync wr_245 fall, push the captured din_245, set txe_245=1, go to W_PRE.
  - W_PRE: txe_245=1 for TXE_PRE cycles, then W_IDLE.
- FIFO pointers:
  - DEPTH_LOG2+1 bits each, wrapping modulo 2^(DEPTH_LOG2+1).
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.
- The read and write FSMs are fully independent and may run concurrently.

Test Plan:
- Reset: hold rst=0 with strobes toggling -> rxf_245=1, txe_245=1, oe_245=0, err flags=0; after release with empty FIFOs, rxf_245 stays 1 and txe_245 goes 0 within 1 cycle.
- PC-to-host read: push 0xA5 via pc_tx; host drops rx_245 -> oe_245=1 and dout_245=0xA5 within 2 sync + RD_LAT cycles; rx_245 rise -> rxf_245=1 for RXF_PRE cycles, then 1 (FIFO now empty).
- Host-to-PC write: pulse wr_245 with din_245=0x3C -> txe_245=1 for TXE_PRE cycles; pc_rx_rdy=1 with pc_rx_data=0x3C; pc_rx_ack -> pc_rx_rdy=0.
- Full/wrap: write 16 bytes 0x00..0x0F -> txe_245 stays 1; drain them and write 16 more bytes 0x10..0x1F -> order preserved across pointer wrap. Fill the RX FIFO the same way -> 17th pc_tx_rdy gets no ack.
- Protocol errors: rx_245 fall while the RX FIFO is empty -> err_rd=1 and stays 1, no pop; wr_245 pulse while the TX FIFO is full -> err_wr=1 and the FIFO is unchanged.
- Concurrency/reset: run a read and a write in overlapping cycles -> both bytes correct; assert rst inside R_DRIVE -> oe_245=0 immediately and both FIFOs empty after release.
